// File: rtl/encoder_pkg.sv
// Shared types and defaults for the constant-weight encoder sequencer.
//   state_e        : sequencer phases (LOAD, KICK, RUN, DRAIN)
//   BYTE_W         : host / FIFO byte width
//   DEF_*          : default message geometry used as parameter defaults
package encoder_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        KICK  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int BYTE_W        = 8;
    localparam int DEF_MSG_BYTES = 5;
    localparam int DEF_CW_NUM    = 10;
    localparam int DEF_CW_W      = 10;

endpackage

// File: rtl/cw_buffer.sv
// Codeword capture buffer: CW_NUM x CW_W register array.
//   clk     : system clock (array is not reset; contents are qualified by indices)
//   we      : write strobe, wr_idx selects the entry, wr_data is stored
//   rd_idx  : combinational read select, rd_data returns the entry (0 if out of range)
module cw_buffer #(
    parameter int CW_NUM = 10,
    parameter int CW_W   = 10,
    parameter int IDX_W  = $clog2(CW_NUM) + 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CW_W-1:0]  wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CW_W-1:0]  rd_data
);

    localparam int AW = (CW_NUM > 1) ? $clog2(CW_NUM) : 1;
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(CW_NUM);

    logic [CW_W-1:0] mem_q [CW_NUM];

    always_ff @(posedge clk) begin
        if (we && (wr_idx < DEPTH))
            mem_q[wr_idx[AW-1:0]] <= wr_data;
    end

    assign rd_data = (rd_idx < DEPTH) ? mem_q[rd_idx[AW-1:0]] : '0;

endmodule

// File: rtl/encoder_ctrl.sv
// Sequencer above encoder_top: loads one message into the encoder FIFO,
// kicks the encoder, captures its codewords and replays them downstream.
//   host_valid/host_byte/host_ready : byte stream in (accepted in LOAD only)
//   enc_msg_byte/enc_wr_en          : registered FIFO write port
//   enc_start                       : one-cycle encoder start
//   enc_cw/enc_cw_rdy/enc_cw_done   : encoder output (cannot be stalled)
//   cw_valid/cw_data/cw_last/cw_ready : buffered codeword replay
//   busy, err                       : status (err sticky until reset)
module encoder_ctrl
    import encoder_pkg::*;
#(
    parameter int MSG_BYTES = DEF_MSG_BYTES,
    parameter int CW_NUM    = DEF_CW_NUM,
    parameter int CW_W      = DEF_CW_W,
    parameter int FIFO_LAT  = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              host_valid,
    input  logic [BYTE_W-1:0] host_byte,
    output logic              host_ready,
    output logic [BYTE_W-1:0] enc_msg_byte,
    output logic              enc_wr_en,
    output logic              enc_start,
    input  logic [CW_W-1:0]   enc_cw,
    input  logic              enc_cw_rdy,
    input  logic              enc_cw_done,
    output logic              cw_valid,
    output logic [CW_W-1:0]   cw_data,
    output logic              cw_last,
    input  logic              cw_ready,
    output logic              busy,
    output logic              err
);

    localparam int BC_W  = $clog2(MSG_BYTES) + 1;
    localparam int IDX_W = $clog2(CW_NUM) + 1;
    localparam int KC_W  = $clog2(FIFO_LAT + 1) + 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(MSG_BYTES - 1);
    localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CW_NUM);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [KC_W-1:0]  KC_END  = KC_W'(FIFO_LAT);
    localparam logic [KC_W-1:0]  KC_ONE  = KC_W'(1);
    localparam logic [WD_W-1:0]  WD_END  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);

    state_e             state_q, state_d;
    logic [BC_W-1:0]    byte_cnt_q;
    logic [KC_W-1:0]    kick_cnt_q;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d, rd_idx_q;
    logic [WD_W-1:0]    wdog_q;
    logic               host_ready_q, enc_wr_en_q, enc_start_q, err_q;
    logic [BYTE_W-1:0]  enc_msg_byte_q;
    logic [CW_W-1:0]    rd_data;

    logic accept, store, drop, wd_hit, rd_valid, rd_last, pop;

    always_comb begin
        accept   = (state_q == LOAD) && host_valid && host_ready_q;
        store    = (state_q == RUN) && enc_cw_rdy && (wr_idx_q != IDX_MAX);
        drop     = (state_q == RUN) && enc_cw_rdy && (wr_idx_q == IDX_MAX);
        wr_idx_d = store ? wr_idx_q + IDX_ONE : wr_idx_q;
        // watchdog would reach TIMEOUT on this edge
        wd_hit   = !enc_cw_rdy && (wdog_q == WD_END);
        rd_valid = (state_q == DRAIN) && (rd_idx_q < wr_idx_q);
        rd_last  = rd_valid && (rd_idx_q + IDX_ONE == wr_idx_q);
        pop      = rd_valid && cw_ready;

        state_d = state_q;
        unique case (state_q)
            LOAD:  if (accept && (byte_cnt_q == BC_LAST)) state_d = KICK;
            KICK:  if (kick_cnt_q == KC_END)              state_d = RUN;
            RUN:   if (enc_cw_done || wd_hit)             state_d = DRAIN;
            // an empty buffer falls straight through to LOAD
            DRAIN: if (!rd_valid || (pop && rd_last))     state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= LOAD;
            byte_cnt_q     <= '0;
            kick_cnt_q     <= '0;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            wdog_q         <= '0;
            host_ready_q   <= 1'b0;
            enc_wr_en_q    <= 1'b0;
            enc_start_q    <= 1'b0;
            enc_msg_byte_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            // registered from next state so it drops on the edge taking the last byte
            host_ready_q <= (state_d == LOAD);
            enc_wr_en_q  <= accept;
            enc_start_q  <= (state_q == KICK) && (state_d == RUN);
            kick_cnt_q   <= (state_q == KICK) ? kick_cnt_q + KC_ONE : '0;

            if (accept) begin
                enc_msg_byte_q <= host_byte;
                byte_cnt_q     <= byte_cnt_q + BC_ONE;
            end

            case (state_q)
                KICK: if (state_d == RUN) begin
                    wr_idx_q <= '0;
                    wdog_q   <= '0;
                end
                RUN: begin
                    wr_idx_q <= wr_idx_d;
                    wdog_q   <= enc_cw_rdy ? '0 : wdog_q + WD_ONE;
                    // overflow, timeout, or wrong word count at done
                    if (drop || wd_hit || (enc_cw_done && (wr_idx_d != IDX_MAX)))
                        err_q <= 1'b1;
                end
                DRAIN: begin
                    if (pop) rd_idx_q <= rd_idx_q + IDX_ONE;
                    if (state_d == LOAD) begin
                        byte_cnt_q <= '0;
                        wr_idx_q   <= '0;
                        rd_idx_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    cw_buffer #(
        .CW_NUM (CW_NUM),
        .CW_W   (CW_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we      (store),
        .wr_idx  (wr_idx_q),
        .wr_data (enc_cw),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data)
    );

    assign host_ready   = host_ready_q;
    assign enc_msg_byte = enc_msg_byte_q;
    assign enc_wr_en    = enc_wr_en_q;
    assign enc_start    = enc_start_q;
    assign cw_valid     = rd_valid;
    // buffer is not reset, so gate data to keep it at zero when idle
    assign cw_data      = rd_valid ? rd_data : '0;
    assign cw_last      = rd_last;
    assign busy         = !((state_q == LOAD) && (byte_cnt_q == '0));
    assign err          = err_q;

endmodule

// File: tb/tb_encoder_ctrl.sv
module tb_encoder_ctrl;

    localparam int MSG_BYTES = 5;
    localparam int CW_NUM    = 10;
    localparam int CW_W      = 10;
    localparam int FIFO_LAT  = 2;
    localparam int TIMEOUT   = 64;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            host_valid;
    logic [7:0]      host_byte;
    logic            host_ready;
    logic [7:0]      enc_msg_byte;
    logic            enc_wr_en;
    logic            enc_start;
    logic [CW_W-1:0] enc_cw;
    logic            enc_cw_rdy;
    logic            enc_cw_done;
    logic            cw_valid;
    logic [CW_W-1:0] cw_data;
    logic            cw_last;
    logic            cw_ready;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    encoder_ctrl #(
        .MSG_BYTES (MSG_BYTES),
        .CW_NUM    (CW_NUM),
        .CW_W      (CW_W),
        .FIFO_LAT  (FIFO_LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .host_valid   (host_valid),
        .host_byte    (host_byte),
        .host_ready   (host_ready),
        .enc_msg_byte (enc_msg_byte),
        .enc_wr_en    (enc_wr_en),
        .enc_start    (enc_start),
        .enc_cw       (enc_cw),
        .enc_cw_rdy   (enc_cw_rdy),
        .enc_cw_done  (enc_cw_done),
        .cw_valid     (cw_valid),
        .cw_data      (cw_data),
        .cw_last      (cw_last),
        .cw_ready     (cw_ready),
        .busy         (busy),
        .err          (err)
    );

    int checks = 0;
    int errors = 0;

    // FIFO-side monitor: running totals only, snapshotted by the main sequence
    int         cyc = 0;
    int         wr_total = 0;
    int         start_total = 0;
    int         last_wr_cyc = 0;
    int         start_cyc = 0;
    logic [7:0] wr_bytes[$];

    always @(negedge clk) begin
        cyc++;
        if (enc_wr_en) begin
            wr_total++;
            wr_bytes.push_back(enc_msg_byte);
            last_wr_cyc = cyc;
        end
        if (enc_start) begin
            start_total++;
            start_cyc = cyc;
        end
    end

    logic [7:0] msg [MSG_BYTES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW_W-1:0] wv(input int k, input int seed);
        logic [31:0] t;
        t = k * 71 + seed * 13 + 5;
        return t[CW_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        host_valid = 0; enc_cw_rdy = 0; enc_cw_done = 0; cw_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
    endtask

    task automatic send_msg(input bit gaps);
        bit took;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (gaps) begin
                host_valid = 1'b0;
                tick();
            end
            host_valid = 1'b1;
            host_byte  = msg[i];
            took = 1'b0;
            for (int n = 0; n < 20 && !took; n++) begin
                @(negedge clk);
                took = host_ready;
                tick();
            end
            if (!took) chk($sformatf("host_accept_timeout%0d", i), 0, 1);
        end
        host_valid = 1'b0;
    endtask

    // poke: keep offering a byte while outside LOAD; it must be ignored
    task automatic wait_start(input bit poke);
        bit seen;
        seen = 1'b0;
        if (poke) begin
            host_valid = 1'b1;
            host_byte  = 8'hEE;
        end
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (n == 0) chk("busy_kick", busy, 1);
            seen = enc_start;
        end
        if (!seen) chk("start_timeout", 0, 1);
        tick();
        host_valid = 1'b0;
    endtask

    task automatic check_bytes(input int wr0, input int b0);
        chk("wr_en_count", wr_total - wr0, MSG_BYTES);
        if (wr_bytes.size() >= b0 + MSG_BYTES)
            for (int i = 0; i < MSG_BYTES; i++)
                chk($sformatf("fifo_byte%0d", i), wr_bytes[b0 + i], msg[i]);
    endtask

    // mode 0: done in a separate cycle, 1: done with last word, 2: no done
    task automatic emit(input int n, input int mode, input int seed);
        for (int k = 0; k < n; k++) begin
            enc_cw_rdy  = 1'b1;
            enc_cw      = wv(k, seed);
            enc_cw_done = (mode == 1) && (k == n - 1);
            tick();
        end
        enc_cw_rdy  = 1'b0;
        enc_cw_done = 1'b0;
        if (mode == 0) begin
            enc_cw_done = 1'b1;
            tick();
            enc_cw_done = 1'b0;
        end
    endtask

    task automatic drain(input int n, input int seed, input int pct, output int span);
        int idx, first_it, last_it;
        bit stall;
        logic [CW_W-1:0] pd;
        idx = 0; stall = 0; pd = '0; first_it = -1; last_it = 0;
        for (int it = 0; it < 400 && idx < n; it++) begin
            cw_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (stall) begin
                chk("stall_valid", cw_valid, 1);
                chk("stall_data", cw_data, pd);
            end
            if (cw_valid && first_it < 0) first_it = it;
            if (cw_valid && cw_ready) begin
                chk($sformatf("word%0d", idx), cw_data, wv(idx, seed));
                chk($sformatf("last%0d", idx), cw_last, (idx == n - 1));
                idx++;
                last_it = it;
            end
            stall = cw_valid && !cw_ready;
            pd    = cw_data;
            tick();
        end
        cw_ready = 1'b0;
        chk("drain_count", idx, n);
        span = last_it - first_it + 1;
        @(negedge clk);
        chk("post_drain_valid", cw_valid, 0);
        chk("post_drain_ready", host_ready, 1);
        chk("post_drain_busy", busy, 0);
        tick();
    endtask

    initial begin
        int wr0, b0, st0, span, got;

        // ---------------- reset values ----------------
        rst_b = 1'b1;
        host_valid = 0; host_byte = 0; enc_cw = 0; enc_cw_rdy = 0;
        enc_cw_done = 0; cw_ready = 0;
        #1 rst_b = 1'b0;
        #2;
        chk("rst_host_ready", host_ready, 0);
        chk("rst_wr_en", enc_wr_en, 0);
        chk("rst_start", enc_start, 0);
        chk("rst_cw_valid", cw_valid, 0);
        chk("rst_cw_last", cw_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_msg_byte", enc_msg_byte, 0);
        chk("rst_cw_data", cw_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1 chk("ready_after_release", host_ready, 0);
        tick();
        chk("ready_one_cycle", host_ready, 1);

        // ---------------- nominal ----------------
        msg[0] = 8'hA5; msg[1] = 8'h3C; msg[2] = 8'h00; msg[3] = 8'hFF; msg[4] = 8'h12;
        wr0 = wr_total; b0 = wr_bytes.size(); st0 = start_total;
        send_msg(0);
        @(negedge clk);
        chk("ready_fell", host_ready, 0);
        chk("busy_loaded", busy, 1);
        wait_start(1);
        check_bytes(wr0, b0);
        chk("start_lat", start_cyc - last_wr_cyc, FIFO_LAT + 1);
        emit(10, 0, 1);
        drain(10, 1, 100, span);
        chk("throughput_span", span, 10);
        chk("start_pulses", start_total - st0, 1);
        chk("nom_err", err, 0);

        // ---------------- host gaps + backpressure ----------------
        wr0 = wr_total; b0 = wr_bytes.size();
        send_msg(1);
        wait_start(0);
        check_bytes(wr0, b0);
        emit(10, 0, 1);
        drain(10, 1, 30, span);
        chk("gap_err", err, 0);

        // ---------------- same-cycle done ----------------
        msg[0] = 8'h01; msg[1] = 8'h80; msg[2] = 8'h7E; msg[3] = 8'h55; msg[4] = 8'hC3;
        wr0 = wr_total; b0 = wr_bytes.size();
        send_msg(0);
        wait_start(0);
        check_bytes(wr0, b0);
        emit(10, 1, 2);
        drain(10, 2, 100, span);
        chk("same_err", err, 0);

        // ---------------- miscount: 9 words ----------------
        send_msg(0);
        wait_start(0);
        emit(9, 0, 3);
        drain(9, 3, 60, span);
        chk("short_err", err, 1);
        do_reset();
        chk("short_err_cleared", err, 0);

        // ---------------- miscount: 11 words ----------------
        send_msg(0);
        wait_start(0);
        emit(11, 0, 4);
        chk("long_err", err, 1);
        drain(10, 4, 100, span);
        do_reset();

        // ---------------- watchdog ----------------
        send_msg(0);
        wait_start(0);
        emit(3, 2, 5);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        chk("wdog_not_yet", err, 0);
        @(posedge clk);
        @(negedge clk);
        chk("wdog_err", err, 1);
        tick();
        drain(3, 5, 100, span);

        // ---------------- reset mid-DRAIN ----------------
        send_msg(0);
        wait_start(0);
        emit(10, 1, 6);
        cw_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && got < 2; n++) begin
            @(negedge clk);
            if (cw_valid) got++;
            tick();
        end
        cw_ready = 1'b0;
        chk("middrain_got", got, 2);
        #2 rst_b = 1'b0;
        #1;
        chk("mid_cw_valid", cw_valid, 0);
        chk("mid_cw_data", cw_data, 0);
        chk("mid_cw_last", cw_last, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_host_ready", host_ready, 0);
        chk("mid_msg_byte", enc_msg_byte, 0);
        @(negedge clk);
        rst_b = 1'b1;
        #1 chk("mid_ready_release", host_ready, 0);
        tick();
        chk("mid_ready_one_cycle", host_ready, 1);
        chk("mid_valid_after", cw_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
